rst_sequencer: RTL and testbench

- Parametrised reset/clock-domain bring-up controller; next generation of the bench clock/reset generator.
- Synchronises deassertion of a raw asynchronous reset, then releases N channel resets in a fixed staggered order.
- Counts run cycles and raises a sticky watchdog timeout.
- Accepts a soft-reset request that re-runs the sequence.
- Sits between the top-level reset source and the core/peripheral reset inputs.

---
 rtl/rst_seq_pkg.sv | 36 +++
 rtl/rst_sync.sv | 34 +++
 rtl/rst_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_rst_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types, parameter defaults and sizing helpers for the reset sequencer.
//
// Contents:
//   state_e         sequencer FSM state encoding
//   Def*            default values for every rst_sequencer parameter
//   width_for()     counter width needed to hold a value in [0, max_val]
//   max3()          largest of three integers
package rst_seq_pkg;

   typedef enum logic [2:0] {
      WAIT_SYNC,
      HOLD,
      RELEASE,
      RUN,
      SOFT
   } state_e;

   localparam int DefNumChannels     = 4;
   localparam int DefSyncStages      = 2;
   localparam int DefHoldCycles      = 2;
   localparam int DefGapCycles       = 1;
   localparam int DefSoftPulseCycles = 4;
   localparam int DefCountWidth      = 32;
   localparam int DefMaxCycleCount   = 16384;

   function automatic int width_for(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchroniser.
//
// The chain clears immediately when rst_n_i falls and shifts in ones once it
// rises, so rst_n_sync_o goes high SyncStages posedges after deassertion.
//
// Ports:
//   clk_i         clock
//   rst_n_i       raw asynchronous active-low reset
//   rst_n_sync_o  synchronised active-low reset
module rst_sync #(
   parameter int SyncStages = rst_seq_pkg::DefSyncStages
) (
   input  logic clk_i,
   input  logic rst_n_i,
   output logic rst_n_sync_o
);

   if (SyncStages < 2) begin : g_bad_stages
      $error("rst_sync: SyncStages must be >= 2");
   end

   logic [SyncStages-1:0] chain_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[SyncStages-2:0], 1'b1};
      end
   end

   assign rst_n_sync_o = chain_q[SyncStages-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset / clock-domain bring-up sequencer.
//
// Synchronises the release of a raw reset, then releases NumChannels channel
// resets one after another (bit 0 first), counts cycles spent in RUN and
// raises a sticky watchdog flag. A soft request re-runs the sequence without
// clearing the watchdog flag.
//
// Build option: define RST_SEQ_SIM_FINISH_EN to make the block print the
// cycle count and end simulation on the edge the watchdog fires. Without it
// the block contains no system tasks.
//
// Ports:
//   clk_i           clock, all logic on posedge
//   rst_n_i         asynchronous active-low reset (sync deassertion inside)
//   soft_rst_req_i  soft re-sequence request, sampled on posedge
//   rst_n_o         per-channel active-low resets
//   all_released_o  every channel released (state RUN)
//   busy_o          sequencing in progress (state != RUN)
//   cycle_count_o   posedges elapsed in RUN, saturating
//   timeout_o       sticky watchdog flag
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_SYNC | raw reset released, waiting for the synchroniser output
// HOLD      | all channels in reset, counting down before channel 0
// RELEASE   | channels released one by one, gap timer between them
// RUN       | all channels released, run counter and watchdog active
// SOFT      | soft request: all channels forced into reset for a pulse
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NumChannels     = DefNumChannels,
   parameter int SyncStages      = DefSyncStages,
   parameter int HoldCycles      = DefHoldCycles,
   parameter int GapCycles       = DefGapCycles,
   parameter int SoftPulseCycles = DefSoftPulseCycles,
   parameter int CountWidth      = DefCountWidth,
   parameter int MaxCycleCount   = DefMaxCycleCount
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   soft_rst_req_i,
   output logic [NumChannels-1:0] rst_n_o,
   output logic                   all_released_o,
   output logic                   busy_o,
   output logic [CountWidth-1:0]  cycle_count_o,
   output logic                   timeout_o
);

   if (NumChannels < 1) begin : g_bad_channels
      $error("rst_sequencer: NumChannels must be >= 1");
   end
   if (SyncStages < 2) begin : g_bad_sync
      $error("rst_sequencer: SyncStages must be >= 2");
   end
   if (HoldCycles < 1) begin : g_bad_hold
      $error("rst_sequencer: HoldCycles must be >= 1");
   end
   if (GapCycles < 0) begin : g_bad_gap
      $error("rst_sequencer: GapCycles must be >= 0");
   end
   if (SoftPulseCycles < 1) begin : g_bad_soft
      $error("rst_sequencer: SoftPulseCycles must be >= 1");
   end
   if (CountWidth < 1) begin : g_bad_width
      $error("rst_sequencer: CountWidth must be >= 1");
   end
   if (MaxCycleCount < 0) begin : g_bad_max_neg
      $error("rst_sequencer: MaxCycleCount must be >= 0");
   end
   if (CountWidth < 31 && MaxCycleCount >= (1 << CountWidth)) begin : g_bad_max_fit
      $error("rst_sequencer: MaxCycleCount does not fit in CountWidth bits");
   end

   // Timer loads are "cycles - 1" so terminal count 0 lands on the target edge.
   localparam int TimerW = width_for(max3(HoldCycles - 1, GapCycles, SoftPulseCycles - 1));
   localparam int ChW    = width_for(NumChannels - 1);

   localparam logic [TimerW-1:0]     HoldLoad = TimerW'(HoldCycles - 1);
   localparam logic [TimerW-1:0]     GapLoad  = TimerW'(GapCycles);
   localparam logic [TimerW-1:0]     SoftLoad = TimerW'(SoftPulseCycles - 1);
   localparam logic [ChW-1:0]        LastCh   = ChW'(NumChannels - 1);
   localparam logic [CountWidth-1:0] WdogThr  = CountWidth'(MaxCycleCount);
   localparam bit                    WdogEn   = (MaxCycleCount != 0);

   state_e                 state_q, state_d;
   logic [TimerW-1:0]      timer_q, timer_d;
   logic [ChW-1:0]         ch_idx_q, ch_idx_d;
   logic [NumChannels-1:0] rst_q, rst_d;
   logic [CountWidth-1:0]  count_q, count_d;
   logic                   timeout_q, timeout_d;

   logic                   sync_rst_n;
   logic                   soft_take;
   logic [NumChannels-1:0] chan_bit;

   rst_sync #(
      .SyncStages (SyncStages)
   ) u_rst_sync (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .rst_n_sync_o (sync_rst_n)
   );

   assign chan_bit = NumChannels'(1) << ch_idx_q;

   // Requests during WAIT_SYNC or SOFT are dropped, so a pulse is never stretched.
   assign soft_take = soft_rst_req_i && (state_q inside {HOLD, RELEASE, RUN});

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      ch_idx_d  = ch_idx_q;
      rst_d     = rst_q;
      count_d   = count_q;
      timeout_d = timeout_q;

      // Soft request has priority over the final release on the same edge.
      if (soft_take) begin
         state_d  = SOFT;
         timer_d  = SoftLoad;
         ch_idx_d = '0;
         rst_d    = '0;
         count_d  = '0;
      end else begin
         unique case (state_q)
            WAIT_SYNC: begin
               if (sync_rst_n) begin
                  state_d  = HOLD;
                  timer_d  = HoldLoad;
                  ch_idx_d = '0;
               end
            end
            HOLD, RELEASE: begin
               if (timer_q == '0) begin
                  rst_d = rst_q | chan_bit;
                  if (ch_idx_q == LastCh) begin
                     state_d = RUN;
                  end else begin
                     state_d  = RELEASE;
                     ch_idx_d = ch_idx_q + ChW'(1);
                     timer_d  = GapLoad;
                  end
               end else begin
                  timer_d = timer_q - TimerW'(1);
               end
            end
            RUN: begin
               if (count_q != '1) begin
                  count_d = count_q + CountWidth'(1);
               end
               if (WdogEn && (count_d == WdogThr)) begin
                  timeout_d = 1'b1;
               end
            end
            SOFT: begin
               if (timer_q == '0) begin
                  state_d  = HOLD;
                  timer_d  = HoldLoad;
                  ch_idx_d = '0;
               end else begin
                  timer_d = timer_q - TimerW'(1);
               end
            end
            default: begin
               state_d = WAIT_SYNC;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= WAIT_SYNC;
         timer_q   <= '0;
         ch_idx_q  <= '0;
         rst_q     <= '0;
         count_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         ch_idx_q  <= ch_idx_d;
         rst_q     <= rst_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
      end
   end

   assign rst_n_o        = rst_q;
   assign all_released_o = (state_q == RUN);
   assign busy_o         = (state_q != RUN);
   assign cycle_count_o  = count_q;
   assign timeout_o      = timeout_q;

`ifdef RST_SEQ_SIM_FINISH_EN
   always @(posedge clk_i) begin
      if (rst_n_i && timeout_d && !timeout_q) begin
         $display("rst_sequencer: watchdog timeout, cycle_count_o=%0d", count_d);
         $finish;
      end
   end
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer (default parameters, MaxCycleCount = 8).
//
// Expected values are tagged with (epoch, edge): epoch counts rst_n_i
// assertions, edge counts posedges since rst_n_i last rose (0 while held in
// reset). The monitor samples 1 ns after every negedge and 1 ns after every
// rst_n_i fall, and compares against the head of the queue when the tag matches.
module tb_rst_sequencer;

   localparam int TmoEdge = 19;  // RUN entered at edge 11, count reaches 8 at edge 19

   typedef struct {
      int          ep;
      int          e;
      logic [3:0]  rst;
      logic        ar;
      logic        busy;
      logic [31:0] cnt;
      logic        tmo;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        soft_rst_req_i = 1'b0;
   logic [3:0]  rst_n_o;
   logic        all_released_o;
   logic        busy_o;
   logic [31:0] cycle_count_o;
   logic        timeout_o;

   int   epoch = 0;
   int   ecnt = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   rst_sequencer #(
      .MaxCycleCount (8)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n_i),
      .soft_rst_req_i (soft_rst_req_i),
      .rst_n_o        (rst_n_o),
      .all_released_o (all_released_o),
      .busy_o         (busy_o),
      .cycle_count_o  (cycle_count_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) ecnt <= 0;
      else          ecnt <= ecnt + 1;
   end

   // Expected outputs at edge e for a sequence whose HOLD edge is h:
   // channel k released at h + 2 + 2k, RUN from h + 8.
   function automatic exp_t mk(input int ep, input int e, input int h);
      exp_t x;
      int   rel;
      x.ep  = ep;
      x.e   = e;
      x.rst = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         if (e >= h + 2 + 2 * k) x.rst[k] = 1'b1;
      end
      rel    = h + 8;
      x.ar   = (e >= rel);
      x.busy = (e < rel);
      x.cnt  = (e >= rel) ? 32'(e - rel) : 32'd0;
      x.tmo  = (e >= TmoEdge);
      return x;
   endfunction

   function automatic exp_t mk_reset(input int ep);
      exp_t x;
      x.ep   = ep;
      x.e    = 0;
      x.rst  = 4'b0000;
      x.ar   = 1'b0;
      x.busy = 1'b1;
      x.cnt  = 32'd0;
      x.tmo  = 1'b0;
      return x;
   endfunction

   task automatic push_seg(input int ep, input int from, input int to, input int h);
      for (int e = from; e <= to; e++) sb_q.push_back(mk(ep, e, h));
   endtask

   task automatic wait_edge(input int n);
      int guard;
      guard = 0;
      while (ecnt < n && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (ecnt < n) begin
         checks++;
         errors++;
         $display("FAIL wait_edge: reached edge %0d, required %0d", ecnt, n);
      end
   endtask

   task automatic soft_pulse(input int s);
      wait_edge(s - 1);
      soft_rst_req_i = 1'b1;
      wait_edge(s);
      soft_rst_req_i = 1'b0;
   endtask

   // Monitor: pops and compares whenever the head entry's tag is current.
   initial begin
      forever begin
         @(negedge clk or negedge rst_n_i);
         #1;
         while (sb_q.size() > 0 &&
                (sb_q[0].ep < epoch || (sb_q[0].ep == epoch && sb_q[0].e < ecnt))) begin
            checks++;
            errors++;
            $display("FAIL missed ep%0d edge%0d: now ep%0d edge%0d",
                     sb_q[0].ep, sb_q[0].e, epoch, ecnt);
            void'(sb_q.pop_front());
         end
         if (sb_q.size() > 0 && sb_q[0].ep == epoch && sb_q[0].e == ecnt) begin
            exp_t x;
            x = sb_q.pop_front();
            checks++;
            if (rst_n_o !== x.rst || all_released_o !== x.ar || busy_o !== x.busy ||
                cycle_count_o !== x.cnt || timeout_o !== x.tmo) begin
               errors++;
               $display("FAIL outputs ep%0d edge%0d: got rst_n=%b all=%b busy=%b cnt=%0d tmo=%b, want rst_n=%b all=%b busy=%b cnt=%0d tmo=%b",
                        x.ep, x.e, rst_n_o, all_released_o, busy_o, cycle_count_o, timeout_o,
                        x.rst, x.ar, x.busy, x.cnt, x.tmo);
            end
         end
      end
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL sim_time_limit: run did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "time limit");
   end

   initial begin
      // Epoch 0: cold bring-up, watchdog, soft requests.
      sb_q.push_back(mk_reset(0));
      push_seg(0, 1, 29, 3);     // channels at 5,7,9,11; timeout at 19
      push_seg(0, 30, 49, 34);   // soft at 30 -> H=34, channels 36..42
      push_seg(0, 50, 69, 54);   // soft at 50, ignored request at 52 -> H=54
      push_seg(0, 70, 81, 74);   // soft at 70 -> H=74, channels 76,78,80
      push_seg(0, 82, 99, 86);   // soft on final-release edge 82 -> H=86

      repeat (3) @(negedge clk);
      #2 rst_n_i = 1'b1;

      soft_pulse(30);
      soft_pulse(50);
      soft_pulse(52);
      soft_pulse(70);
      soft_pulse(82);
      wait_edge(99);
      #2;

      // Epoch 1: reset asserted from RUN, then dropped again mid-release.
      sb_q.push_back(mk_reset(1));
      push_seg(1, 1, 8, 3);
      epoch = 1;
      rst_n_i = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n_i = 1'b1;
      wait_edge(8);
      #2;

      // Epoch 2: asynchronous drop between edges 8 and 9, then full repeat.
      sb_q.push_back(mk_reset(2));
      push_seg(2, 1, 22, 3);
      epoch = 2;
      rst_n_i = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n_i = 1'b1;
      wait_edge(22);
      repeat (2) @(negedge clk);
      #2;

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
